stack_up_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing the PE stack-bus upstream port between NUM_REQ requesters
//  (requester 0 = SIMD upstream, 1 = PE control/DMA status). Grant is held from SOP to EOP, so packets never interleave.

---
 rtl/stack_up_arbiter_pkg.sv | 28 ++
 rtl/stack_up_skid_fifo.sv | 49 ++++
 rtl/stack_up_arbiter.sv | 152 +++++++++++++++
 tb/tb_stack_up_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_up_arbiter_pkg.sv
// rtl/stack_up_arbiter_pkg.sv - shared encodings and default widths for the stack-bus upstream arbiter
package stack_up_arbiter_pkg;

  localparam int CNTL_W_DEF = 2;
  localparam int TYPE_W_DEF = 2;
  localparam int DATA_W_DEF = 32;
  localparam int OOB_W_DEF  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam logic [CNTL_W_DEF-1:0] CNTL_SOM = 2'd0;
  localparam logic [CNTL_W_DEF-1:0] CNTL_SOP = 2'd1;
  localparam logic [CNTL_W_DEF-1:0] CNTL_MOP = 2'd2;
  localparam logic [CNTL_W_DEF-1:0] CNTL_EOP = 2'd3;

  // A packet opens on SOP or single-beat SOM and closes on EOP or SOM.
  function automatic logic is_start(input logic [CNTL_W_DEF-1:0] c);
    return (c == CNTL_SOP) || (c == CNTL_SOM);
  endfunction

  function automatic logic is_end(input logic [CNTL_W_DEF-1:0] c);
    return (c == CNTL_EOP) || (c == CNTL_SOM);
  endfunction

endpackage

// File: rtl/stack_up_skid_fifo.sv
// rtl/stack_up_skid_fifo.sv - small output FIFO with registered count; outputs read as zero when empty
module stack_up_skid_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_push  = push && (count < CW'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign valid    = (count != '0);
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/stack_up_arbiter.sv
// rtl/stack_up_arbiter.sv - packet-granular round-robin arbiter onto the stack-bus upstream port
module stack_up_arbiter
  import stack_up_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNTL_W  = CNTL_W_DEF,
  parameter int TYPE_W  = TYPE_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OOB_W   = OOB_W_DEF,
  parameter int DEPTH   = 2
) (
  input  logic                      clk,
  input  logic                      reset_poweron,
  input  logic [NUM_REQ-1:0]        req__arb__valid,
  input  logic [NUM_REQ*CNTL_W-1:0] req__arb__cntl,
  output logic [NUM_REQ-1:0]        arb__req__ready,
  input  logic [NUM_REQ*TYPE_W-1:0] req__arb__type,
  input  logic [NUM_REQ*DATA_W-1:0] req__arb__data,
  input  logic [NUM_REQ*OOB_W-1:0]  req__arb__oob_data,
  output logic                      pe__stu__valid,
  output logic [CNTL_W-1:0]         pe__stu__cntl,
  input  logic                      stu__pe__ready,
  output logic [TYPE_W-1:0]         pe__stu__type,
  output logic [DATA_W-1:0]         pe__stu__data,
  output logic [OOB_W-1:0]          pe__stu__oob_data,
  output logic                      arb__cntl__busy,
  output logic [1:0]                arb__cntl__grant_id,
  output logic                      arb__cntl__proto_err
);

  localparam int BEAT_W = CNTL_W + TYPE_W + DATA_W + OOB_W;
  localparam int CW     = $clog2(DEPTH + 1);

  arb_state_t          state_q, next_state;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          rr_q, rr_d;
  logic                in_pkt_q, in_pkt_d;
  logic                err_q, err_d;
  logic                hit;
  logic [1:0]          hit_id;
  logic                sel_valid;
  logic [CNTL_W-1:0]   sel_cntl;
  logic [BEAT_W-1:0]   sel_beat;
  logic                push;
  logic                room;
  logic [CW-1:0]       fifo_count;
  logic [BEAT_W-1:0]   out_beat;

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      in_pkt_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= next_state;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
    end
  end

  // Ready comes only from registered state and count, never from stu__pe__ready.
  assign room = (fifo_count < CW'(DEPTH));

  always_comb begin
    next_state      = state_q;
    grant_d         = grant_q;
    rr_d            = rr_q;
    in_pkt_d        = in_pkt_q;
    err_d           = err_q;
    hit             = 1'b0;
    hit_id          = '0;
    sel_valid       = 1'b0;
    sel_cntl        = '0;
    sel_beat        = '0;
    push            = 1'b0;
    arb__req__ready = '0;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 2'(i)) begin
        sel_valid = req__arb__valid[i];
        sel_cntl  = req__arb__cntl[i*CNTL_W +: CNTL_W];
        sel_beat  = {req__arb__cntl[i*CNTL_W +: CNTL_W], req__arb__type[i*TYPE_W +: TYPE_W],
                     req__arb__data[i*DATA_W +: DATA_W], req__arb__oob_data[i*OOB_W +: OOB_W]};
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        // Scan starts one past the last winner, so the finishing requester is checked last.
        for (int k = 0; k < NUM_REQ; k++) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && ((int'(rr_q) + 1 + k) % NUM_REQ) == i &&
                req__arb__valid[i] && is_start(req__arb__cntl[i*CNTL_W +: CNTL_W])) begin
              hit    = 1'b1;
              hit_id = 2'(i);
            end
          end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
          if (req__arb__valid[i] && !is_start(req__arb__cntl[i*CNTL_W +: CNTL_W])) err_d = 1'b1;
        end
        if (hit) begin
          grant_d    = hit_id;
          in_pkt_d   = 1'b0;
          next_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (grant_q == 2'(i)) arb__req__ready[i] = room;
        end
        push = sel_valid && room;
        if (push) begin
          if (in_pkt_q && is_start(sel_cntl)) err_d = 1'b1;
          if (is_end(sel_cntl)) begin
            rr_d       = grant_q;
            in_pkt_d   = 1'b0;
            next_state = ST_IDLE;
          end else begin
            in_pkt_d = 1'b1;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  stack_up_skid_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (reset_poweron),
    .push      (push),
    .push_data (sel_beat),
    .pop       (stu__pe__ready),
    .valid     (pe__stu__valid),
    .pop_data  (out_beat),
    .count     (fifo_count)
  );

  assign {pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data} = out_beat;

  assign arb__cntl__busy      = (state_q == ST_BUSY);
  assign arb__cntl__grant_id  = grant_q;
  assign arb__cntl__proto_err = err_q;

endmodule

// File: tb/tb_stack_up_arbiter.sv
// tb/tb_stack_up_arbiter.sv - directed self-checking bench for stack_up_arbiter
module tb_stack_up_arbiter;
  import stack_up_arbiter_pkg::*;

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [1:0]  cntl;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rv;
  logic [3:0]  rc;
  logic [1:0]  rr;
  logic [3:0]  rt;
  logic [63:0] rd;
  logic [15:0] ro;
  logic        pv;
  logic [1:0]  pc;
  logic        sr;
  logic [1:0]  pt;
  logic [31:0] pd;
  logic [7:0]  po;
  logic        busy;
  logic [1:0]  gid;
  logic        perr;

  int    total = 0;
  int    bad   = 0;
  beat_t rq [2][$];
  beat_t outlog[$];
  beat_t ex[$];
  logic [1:0] hs = '0;
  int    occ = 0;
  int    acc = 0;
  logic  seen_full = 1'b0;
  logic  stu_mode = 1'b0;
  logic  pat [4];
  int    pi = 0;

  stack_up_arbiter dut (
    .clk                  (clk),
    .reset_poweron        (rst),
    .req__arb__valid      (rv),
    .req__arb__cntl       (rc),
    .arb__req__ready      (rr),
    .req__arb__type       (rt),
    .req__arb__data       (rd),
    .req__arb__oob_data   (ro),
    .pe__stu__valid       (pv),
    .pe__stu__cntl        (pc),
    .stu__pe__ready       (sr),
    .pe__stu__type        (pt),
    .pe__stu__data        (pd),
    .pe__stu__oob_data    (po),
    .arb__cntl__busy      (busy),
    .arb__cntl__grant_id  (gid),
    .arb__cntl__proto_err (perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshakes and an independent occupancy model, sampled mid-cycle.
  always @(negedge clk) begin
    hs = rv & rr;
    if (rst) begin
      occ = 0;
    end else begin
      if (occ == DEPTH) begin
        seen_full = 1'b1;
        chk("full_ready", {62'd0, rr}, 64'd0);
      end
      if (|hs) acc++;
      if (pv && sr) outlog.push_back('{cntl: pc, data: pd});
      occ = occ + ((|hs) ? 1 : 0) - ((pv && sr) ? 1 : 0);
    end
  end

  task automatic present();
    for (int i = 0; i < 2; i++) begin
      if (rq[i].size() > 0) begin
        rv[i]          = 1'b1;
        rc[i*2 +: 2]   = rq[i][0].cntl;
        rd[i*32 +: 32] = rq[i][0].data;
        ro[i*8 +: 8]   = rq[i][0].data[7:0];
      end else begin
        rv[i]          = 1'b0;
        rc[i*2 +: 2]   = '0;
        rd[i*32 +: 32] = '0;
        ro[i*8 +: 8]   = '0;
      end
    end
    rt = 4'b0100;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hs[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    present();
    if (stu_mode) begin
      sr = pat[pi % 4];
      pi++;
    end else begin
      sr = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq[0].delete();
    rq[1].delete();
    stu_mode = 1'b0;
    present();
    sr = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    outlog.delete();
    acc = 0;
  endtask

  task automatic load(input int r, input logic [1:0] c, input logic [31:0] d);
    rq[r].push_back('{cntl: c, data: d});
  endtask

  task automatic add(input logic [1:0] c, input logic [31:0] d);
    ex.push_back('{cntl: c, data: d});
  endtask

  task automatic drain(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (k < budget && !(outlog.size() >= n && rq[0].size() == 0 && rq[1].size() == 0 && !pv)) begin
      step();
      k++;
    end
    chk(tag, 64'(outlog.size()), 64'(n));
  endtask

  task automatic chk_log(input string tag);
    for (int j = 0; j < ex.size(); j++) begin
      if (j < outlog.size()) chk(tag, {30'd0, outlog[j].cntl, outlog[j].data}, {30'd0, ex[j].cntl, ex[j].data});
    end
    ex.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    rst = 1'b1;
    rv = '0; rc = '0; rt = '0; rd = '0; ro = '0; sr = 1'b1;
    step();
    chk("rst_valid", {63'd0, pv}, 64'd0);
    chk("rst_ready", {62'd0, rr}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_gid",   {62'd0, gid}, 64'd0);
    chk("rst_perr",  {63'd0, perr}, 64'd0);
    chk("rst_data",  {32'd0, pd}, 64'd0);
    do_reset();

    // 1: single SOM
    load(0, CNTL_SOM, 32'h0000_1234);
    step();
    step();
    chk("t1_busy",  {63'd0, busy}, 64'd1);
    chk("t1_gid",   {62'd0, gid}, 64'd0);
    chk("t1_ready", {62'd0, rr}, 64'd1);
    chk("t1_pv0",   {63'd0, pv}, 64'd0);
    step();
    chk("t1_pv1",   {63'd0, pv}, 64'd1);
    chk("t1_data",  {32'd0, pd}, 64'h1234);
    chk("t1_oob",   {56'd0, po}, 64'h34);
    chk("t1_cntl",  {62'd0, pc}, {62'd0, CNTL_SOM});
    chk("t1_busy0", {63'd0, busy}, 64'd0);
    step();
    chk("t1_pv_end", {63'd0, pv}, 64'd0);

    // 2: simultaneous 4-beat packets, req1 wins first
    do_reset();
    for (int b = 0; b < 4; b++) begin
      load(0, (b == 0) ? CNTL_SOP : (b == 3) ? CNTL_EOP : CNTL_MOP, 32'hA000_0000 + 32'(b));
      load(1, (b == 0) ? CNTL_SOP : (b == 3) ? CNTL_EOP : CNTL_MOP, 32'hB000_0000 + 32'(b));
    end
    step();
    step();
    chk("t2_busy", {63'd0, busy}, 64'd1);
    chk("t2_gid",  {62'd0, gid}, 64'd1);
    chk("t2_ready", {62'd0, rr}, 64'd2);
    drain("t2_count", 8, 60);
    for (int b = 0; b < 4; b++) add((b == 0) ? CNTL_SOP : (b == 3) ? CNTL_EOP : CNTL_MOP, 32'hB000_0000 + 32'(b));
    for (int b = 0; b < 4; b++) add((b == 0) ? CNTL_SOP : (b == 3) ? CNTL_EOP : CNTL_MOP, 32'hA000_0000 + 32'(b));
    chk_log("t2_beat");

    // 3: 8-beat packet under upstream backpressure 1,0,0,1
    do_reset();
    seen_full = 1'b0;
    pi = 0;
    stu_mode = 1'b1;
    for (int b = 0; b < 8; b++) begin
      load(0, (b == 0) ? CNTL_SOP : (b == 7) ? CNTL_EOP : CNTL_MOP, 32'hC000_0000 + 32'(b));
      add((b == 0) ? CNTL_SOP : (b == 7) ? CNTL_EOP : CNTL_MOP, 32'hC000_0000 + 32'(b));
    end
    drain("t3_count", 8, 100);
    chk_log("t3_beat");
    chk("t3_full_seen", {63'd0, seen_full}, 64'd1);
    stu_mode = 1'b0;

    // 4: second SOP mid-packet is flagged and forwarded
    do_reset();
    chk("t4_perr0", {63'd0, perr}, 64'd0);
    load(0, CNTL_SOP, 32'hD000_0000);
    load(0, CNTL_MOP, 32'hD000_0001);
    load(0, CNTL_SOP, 32'hD000_0002);
    load(0, CNTL_EOP, 32'hD000_0003);
    add(CNTL_SOP, 32'hD000_0000);
    add(CNTL_MOP, 32'hD000_0001);
    add(CNTL_SOP, 32'hD000_0002);
    add(CNTL_EOP, 32'hD000_0003);
    drain("t4_count", 4, 40);
    chk_log("t4_beat");
    chk("t4_perr1", {63'd0, perr}, 64'd1);
    repeat (3) step();
    chk("t4_perr_sticky", {63'd0, perr}, 64'd1);

    // 4b: MOP presented while idle is flagged and not granted
    do_reset();
    chk("t4b_perr0", {63'd0, perr}, 64'd0);
    load(1, CNTL_MOP, 32'hE000_0000);
    step();
    step();
    chk("t4b_perr", {63'd0, perr}, 64'd1);
    chk("t4b_busy", {63'd0, busy}, 64'd0);
    chk("t4b_ready", {62'd0, rr}, 64'd0);

    // 5: reset in the middle of a 6-beat packet
    do_reset();
    for (int b = 0; b < 6; b++) load(0, (b == 0) ? CNTL_SOP : (b == 5) ? CNTL_EOP : CNTL_MOP, 32'hF000_0000 + 32'(b));
    for (int k = 0; k < 30; k++) begin
      step();
      if (acc >= 3) break;
    end
    chk("t5_acc", 64'(acc), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("t5_pv",   {63'd0, pv}, 64'd0);
    chk("t5_data", {32'd0, pd}, 64'd0);
    chk("t5_ready", {62'd0, rr}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_perr", {63'd0, perr}, 64'd0);
    rq[0].delete();
    present();
    repeat (2) step();
    rst = 1'b0;
    outlog.delete();
    acc = 0;
    load(0, CNTL_SOP, 32'h5500_0000);
    load(0, CNTL_EOP, 32'h5500_0001);
    add(CNTL_SOP, 32'h5500_0000);
    add(CNTL_EOP, 32'h5500_0001);
    drain("t5_count", 2, 30);
    chk_log("t5_beat");

    // 6: req1 waits continuously while req0 sends back-to-back packets
    do_reset();
    load(0, CNTL_SOP, 32'h6A00_0000);
    load(0, CNTL_EOP, 32'h6A00_0001);
    load(0, CNTL_SOP, 32'h6A00_0002);
    load(0, CNTL_EOP, 32'h6A00_0003);
    step();
    load(1, CNTL_SOM, 32'h6B00_0000);
    load(1, CNTL_SOM, 32'h6B00_0001);
    step();
    chk("t6_gid", {62'd0, gid}, 64'd0);
    drain("t6_count", 6, 60);
    add(CNTL_SOP, 32'h6A00_0000);
    add(CNTL_EOP, 32'h6A00_0001);
    add(CNTL_SOM, 32'h6B00_0000);
    add(CNTL_SOP, 32'h6A00_0002);
    add(CNTL_EOP, 32'h6A00_0003);
    add(CNTL_SOM, 32'h6B00_0001);
    chk_log("t6_beat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
